// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded hold time: a contended owner
// keeps the resource for at most MAX_HOLD consecutive cycles before rotation.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     fsm_reg, fsm_next;
  logic [1:0] owner_reg, owner_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [7:0] hold_cnt_reg, hold_cnt_next;
  logic [3:0] gnt_reg;

  logic [3:0] others;
  logic [1:0] win_all, win_others, new_owner;
  logic       load;

  // First set bit of mask scanning start, start+1, ... (mod 4); the descending
  // loop lets the smallest offset overwrite the rest.
  function automatic logic [1:0] pick(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] sel;
    sel = start;
    for (int k = 3; k >= 0; k--) begin
      if (mask[start + 2'(k)]) sel = start + 2'(k);
    end
    return sel;
  endfunction

  assign others     = req & ~(4'b0001 << owner_reg);
  assign win_all    = pick(req, ptr_reg);
  assign win_others = pick(others, ptr_reg);

  always_comb begin
    fsm_next      = fsm_reg;
    owner_next    = owner_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    load          = 1'b0;
    new_owner     = owner_reg;
    case (fsm_reg)
      IDLE: begin
        if (|req) begin
          load      = 1'b1;
          new_owner = win_all;
        end
      end
      GRANT: begin
        if (!req[owner_reg]) begin
          // Release: hand straight to the next requester so no idle bubble appears.
          if (|req) begin
            load      = 1'b1;
            new_owner = win_all;
          end else begin
            fsm_next = IDLE;
          end
        end else if ((hold_cnt_reg == HOLD_LAST) && (|others)) begin
          load      = 1'b1;
          new_owner = win_others;
        end else if (hold_cnt_reg != HOLD_LAST) begin
          hold_cnt_next = hold_cnt_reg + 8'd1;
        end
      end
      default: fsm_next = IDLE;
    endcase
    if (load) begin
      fsm_next      = GRANT;
      owner_next    = new_owner;
      ptr_next      = new_owner + 2'd1;
      hold_cnt_next = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_reg      <= IDLE;
      owner_reg    <= 2'd0;
      ptr_reg      <= 2'd0;
      hold_cnt_reg <= 8'd0;
      gnt_reg      <= 4'b0000;
    end else begin
      fsm_reg      <= fsm_next;
      owner_reg    <= owner_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      gnt_reg      <= (fsm_next == GRANT) ? (4'b0001 << owner_next) : 4'b0000;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_idx   = owner_reg;
  assign gnt_valid = (fsm_reg == GRANT);

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed scenarios plus random traffic, checked against
// a tenure-counting round-robin model.
module tb_rr_arbiter_4;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  int vectors = 0;
  int miscompares = 0;

  // Model: who owns, whose turn is next, and how many cycles the owner has held.
  bit m_valid;
  int m_owner;
  int m_next;
  int m_tenure;

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
  );

  always #5 clk = ~clk;

  function automatic int first_from(input logic [3:0] mask, input int start);
    for (int k = 0; k < 4; k++) begin
      if (mask[(start + k) % 4]) return (start + k) % 4;
    end
    return start;
  endfunction

  function automatic void award(input int who);
    m_valid  = 1'b1;
    m_owner  = who;
    m_next   = (who + 1) % 4;
    m_tenure = 1;
  endfunction

  function automatic void model_step(input logic rn, input logic [3:0] r);
    logic [3:0] rest;
    if (!rn) begin
      m_valid = 1'b0; m_owner = 0; m_next = 0; m_tenure = 0;
      return;
    end
    rest = r;
    rest[m_owner] = 1'b0;
    if (!m_valid) begin
      if (r != 4'b0) award(first_from(r, m_next));
    end else if (!r[m_owner]) begin
      if (r != 4'b0) award(first_from(r, m_next));
      else m_valid = 1'b0;
    end else if (m_tenure >= MAX_HOLD && rest != 4'b0) begin
      award(first_from(rest, m_next));
    end else begin
      m_tenure++;
    end
  endfunction

  task automatic apply(input string tag, input logic rn, input logic [3:0] r);
    logic [3:0] exp_gnt;
    rst_n = rn;
    req   = r;
    @(posedge clk);
    model_step(rn, r);
    #1;
    exp_gnt = m_valid ? (4'b0001 << m_owner) : 4'b0000;
    vectors++;
    assert (gnt === exp_gnt) else begin
      miscompares++;
      $error("FAIL %s gnt: got %b want %b (req %b)", tag, gnt, exp_gnt, r);
    end
    vectors++;
    assert (gnt_valid === m_valid) else begin
      miscompares++;
      $error("FAIL %s gnt_valid: got %b want %b", tag, gnt_valid, m_valid);
    end
    vectors++;
    assert (gnt_idx === 2'(m_owner)) else begin
      miscompares++;
      $error("FAIL %s gnt_idx: got %0d want %0d", tag, gnt_idx, m_owner);
    end
    $display("%s rst_n=%b req=%b gnt=%b idx=%0d valid=%b", tag, rn, r, gnt, gnt_idx, gnt_valid);
  endtask

  initial begin
    logic [3:0] r;
    rst_n = 1'b0;
    req   = 4'b1111;
    m_valid = 1'b0; m_owner = 0; m_next = 0; m_tenure = 0;

    apply("reset", 1'b0, 4'b1111);
    apply("reset", 1'b0, 4'b1111);

    // Fair rotation: 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 again.
    for (int i = 0; i < 18; i++) apply("rotate", 1'b1, 4'b1111);

    apply("to_idle", 1'b1, 4'b0000);
    apply("single", 1'b1, 4'b0100);
    apply("single_rel", 1'b1, 4'b0000);
    apply("ptr_after", 1'b1, 4'b1111);   // next pointer is 3, so 1000 wins

    apply("to_idle", 1'b1, 4'b0000);
    apply("handoff", 1'b1, 4'b0010);
    apply("handoff", 1'b1, 4'b0010);
    apply("handoff", 1'b1, 4'b1001);     // 3 precedes 0 after owner 1
    apply("handoff", 1'b1, 4'b1001);

    apply("to_idle", 1'b1, 4'b0000);
    for (int i = 0; i < 10; i++) apply("lone", 1'b1, 4'b0001);
    apply("contend", 1'b1, 4'b0011);
    apply("contend", 1'b1, 4'b0011);

    apply("to_idle", 1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) apply("midgrant", 1'b1, 4'b0100);
    apply("midreset", 1'b0, 4'b0100);
    apply("regrant", 1'b1, 4'b0100);
    apply("regrant", 1'b1, 4'b0100);
    for (int i = 0; i < 6; i++) apply("restart", 1'b1, 4'b1100);

    for (int i = 0; i < 300; i++) begin
      r = 4'($urandom_range(0, 15));
      apply("random", ($urandom_range(0, 49) != 0), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
